// File: rtl/read_data_checker.sv
// rtl/read_data_checker.sv - in-order read-data checker for the memory tester
// Queues issued read addresses and compares returned words against the expected pattern.
module read_data_checker #(
  parameter int ADDR_W     = 26,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              test_start_i,
  input  logic [DATA_W-1:0] data_pattern_i,
  input  logic              addr_xor_en_i,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              rd_valid_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              fifo_full_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [31:0]       err_cnt_o,
  output logic [ADDR_W-1:0] err_addr_o,
  output logic [DATA_W-1:0] err_data_o,
  output logic              proto_err_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

  logic [ADDR_W-1:0] mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              err_q, err_d;
  logic [31:0]       err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [DATA_W-1:0] err_data_q, err_data_d;
  logic              proto_err_q, proto_err_d;

  logic              full, empty, push, pop, mismatch, mem_we;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] expected;

  always_comb begin
    full      = (occ_q == OCC_FULL);
    empty     = (occ_q == '0);
    pop       = rd_valid_i && !empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts the push.
    push      = rd_req_i && (!full || pop);
    head_addr = mem_q[rd_ptr_q];
    expected  = addr_xor_en_i ? (data_pattern_i ^ DATA_W'(head_addr)) : data_pattern_i;
    mismatch  = pop && (rd_data_i != expected);
    mem_we    = push && !test_start_i;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;
    err_addr_d  = err_addr_q;
    err_data_d  = err_data_q;
    proto_err_d = proto_err_q;

    if (test_start_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      occ_d       = '0;
      err_d       = 1'b0;
      err_cnt_d   = '0;
      err_addr_d  = '0;
      err_data_d  = '0;
      proto_err_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      occ_d = occ_q + 1'b1;
      else if (pop && !push) occ_d = occ_q - 1'b1;

      if ((rd_req_i && !push) || (rd_valid_i && empty)) proto_err_d = 1'b1;

      if (mismatch) begin
        if (err_cnt_q != 32'hFFFF_FFFF) err_cnt_d = err_cnt_q + 32'd1;
        if (!err_q) begin
          err_addr_d = head_addr;
          err_data_d = rd_data_i;
        end
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      err_addr_q  <= '0;
      err_data_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      err_addr_q  <= err_addr_d;
      err_data_q  <= err_data_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[wr_ptr_q] <= rd_addr_i;
  end

  assign fifo_full_o = full;
  assign busy_o      = !empty;
  assign err_o       = err_q;
  assign err_cnt_o   = err_cnt_q;
  assign err_addr_o  = err_addr_q;
  assign err_data_o  = err_data_q;
  assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_read_data_checker.sv
// tb/tb_read_data_checker.sv - self-checking bench for read_data_checker
// Directed and random steps compared against a queue-based reference model.
module tb_read_data_checker;

  localparam int AW = 26;
  localparam int DW = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          test_start;
  logic [DW-1:0] pattern;
  logic          xor_en;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          fifo_full, busy, err, proto_err;
  logic [31:0]   err_cnt;
  logic [AW-1:0] err_addr;
  logic [DW-1:0] err_data;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] m_q[$];
  logic          m_err, m_proto;
  logic [31:0]   m_cnt;
  logic [AW-1:0] m_eaddr;
  logic [DW-1:0] m_edata;

  always #5 clk = ~clk;

  read_data_checker #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .test_start_i(test_start), .data_pattern_i(pattern),
    .addr_xor_en_i(xor_en), .rd_req_i(rd_req), .rd_addr_i(rd_addr),
    .rd_valid_i(rd_valid), .rd_data_i(rd_data), .fifo_full_o(fifo_full),
    .busy_o(busy), .err_o(err), .err_cnt_o(err_cnt), .err_addr_o(err_addr),
    .err_data_o(err_data), .proto_err_o(proto_err)
  );

  function automatic logic [DW-1:0] exp_of(input logic [AW-1:0] a);
    return xor_en ? (pattern ^ {{(DW-AW){1'b0}}, a}) : pattern;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_err = 1'b0; m_proto = 1'b0; m_cnt = '0; m_eaddr = '0; m_edata = '0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".full"}, 64'(fifo_full), 64'(m_q.size() == DEPTH));
    check({tag, ".busy"}, 64'(busy), 64'(m_q.size() != 0));
    check({tag, ".err"}, 64'(err), 64'(m_err));
    check({tag, ".cnt"}, 64'(err_cnt), 64'(m_cnt));
    check({tag, ".eaddr"}, 64'(err_addr), 64'(m_eaddr));
    check({tag, ".edata"}, 64'(err_data), 64'(m_edata));
    check({tag, ".proto"}, 64'(proto_err), 64'(m_proto));
  endtask

  // One clock cycle: drive, clock, update model from the behavioural rules, then check.
  task automatic cyc(input string tag, input logic req, input logic [AW-1:0] addr,
                     input logic vld, input logic [DW-1:0] data, input logic start);
    logic was_empty, was_full, do_pop, do_push;
    logic [AW-1:0] head;
    rd_req = req; rd_addr = addr; rd_valid = vld; rd_data = data; test_start = start;
    @(posedge clk);
    if (start) model_clear();
    else begin
      was_empty = (m_q.size() == 0);
      was_full  = (m_q.size() == DEPTH);
      do_pop    = vld && !was_empty;
      do_push   = req && (!was_full || do_pop);
      if (vld && was_empty) m_proto = 1'b1;
      if (req && !do_push) m_proto = 1'b1;
      if (do_pop) begin
        head = m_q.pop_front();
        if (data != exp_of(head)) begin
          if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
          if (!m_err) begin m_eaddr = head; m_edata = data; end
          m_err = 1'b1;
        end
      end
      if (do_push) m_q.push_back(addr);
    end
    #1;
    check_all(tag);
    rd_req = 0; rd_valid = 0; test_start = 0;
  endtask

  task automatic push(input string tag, input logic [AW-1:0] a);
    cyc(tag, 1'b1, a, 1'b0, '0, 1'b0);
  endtask

  task automatic pop_good(input string tag);
    cyc(tag, 1'b0, '0, 1'b1, exp_of(m_q[0]), 1'b0);
  endtask

  task automatic pop_data(input string tag, input logic [DW-1:0] d);
    cyc(tag, 1'b0, '0, 1'b1, d, 1'b0);
  endtask

  task automatic clear(input string tag);
    cyc(tag, 1'b0, '0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic r, v;
    rst = 1'b1; test_start = 0; pattern = 32'hA5A5_A5A5; xor_en = 1'b1;
    rd_req = 0; rd_addr = '0; rd_valid = 0; rd_data = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;
    clear("start0");

    // Basic match: addresses 0..7 returned as pattern ^ addr.
    for (int i = 0; i < 8; i++) push("basic_push", AW'(i));
    for (int i = 0; i < 8; i++) pop_good("basic_pop");
    check("basic.busy_fell", 64'(busy), 64'd0);
    check("basic.cnt_zero", 64'(err_cnt), 64'd0);

    // First-error capture.
    clear("start1");
    push("fe_push", AW'('h10));
    push("fe_push", AW'('h11));
    push("fe_push", AW'('h12));
    pop_good("fe_pop0");
    pop_data("fe_pop1", 32'hDEAD_BEEF);
    pop_data("fe_pop2", 32'h0);
    check("fe.cnt", 64'(err_cnt), 64'd2);
    check("fe.addr", 64'(err_addr), 64'h11);
    check("fe.data", 64'(err_data), 64'hDEAD_BEEF);

    // Full, push+pop while full, sustained wrap.
    clear("start2");
    xor_en = 1'b0; pattern = 32'h1234_5678;
    for (int i = 0; i < DEPTH; i++) push("full_push", AW'($urandom));
    check("full.flag", 64'(fifo_full), 64'd1);
    xor_en = 1'b1;
    cyc("full_pp", 1'b1, AW'('h3ABC), 1'b1, exp_of(m_q[0]), 1'b0);
    check("full.stays", 64'(fifo_full), 64'd1);
    for (int i = 0; i < 40; i++)
      cyc("wrap_pp", 1'b1, AW'($urandom), 1'b1, exp_of(m_q[0]), 1'b0);
    check("wrap.cnt", 64'(err_cnt), 64'd0);
    // Overflow: 17th push with no pop.
    push("ovf_push", AW'('h55));
    check("ovf.proto", 64'(proto_err), 64'd1);
    check("ovf.full", 64'(fifo_full), 64'd1);
    for (int i = 0; i < DEPTH; i++) pop_good("ovf_drain");

    // Underflow: read data with empty queue, and push+valid on empty.
    clear("start3");
    pop_data("udf", 32'hFFFF_0000);
    check("udf.cnt", 64'(err_cnt), 64'd0);
    check("udf.proto", 64'(proto_err), 64'd1);
    clear("start4");
    cyc("nobypass", 1'b1, AW'('h7), 1'b1, 32'h0, 1'b0);
    pop_good("nobypass_pop");

    // Saturation.
    clear("start5");
    @(negedge clk);
    force dut.err_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.err_cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      push("sat_push", AW'(i));
      pop_data("sat_pop", ~exp_of(m_q[0]));
    end
    check("sat.cnt", 64'(err_cnt), 64'hFFFF_FFFF);

    // test_start overrides a mismatching rd_valid.
    push("clr_push", AW'('h2));
    cyc("clr_start", 1'b1, AW'('h3), 1'b1, 32'hBAD0_BAD0, 1'b1);
    check("clr.busy", 64'(busy), 64'd0);

    // Random traffic, including protocol errors and mismatches.
    pattern = $urandom;
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 0) begin xor_en = $urandom_range(0, 1); clear("rnd_start"); end
      r = ($urandom_range(0, 9) < 6);
      v = ($urandom_range(0, 9) < 6);
      a = AW'($urandom);
      d = (m_q.size() != 0 && $urandom_range(0, 7) != 0) ? exp_of(m_q[0]) : DW'($urandom);
      cyc("rnd", r, a, v, d, 1'b0);
    end

    // Asynchronous reset with outstanding reads.
    clear("start6");
    for (int i = 0; i < 5; i++) push("rst_push", AW'(i + 'h40));
    pop_data("rst_bad", 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_clear();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    push("post_rst_push", AW'('h9));
    pop_good("post_rst_pop");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
